// File: rtl/miniled_pkg.sv
// rtl/miniled_pkg.sv - gray-mode codes and scheduler state encoding shared by the MiniLED control path
package miniled_pkg;

  typedef enum logic [1:0] {
    GRAY_RMS = 2'd0,
    GRAY_MAX = 2'd1,
    GRAY_AVE = 2'd2,
    GRAY_COR = 2'd3
  } gray_mode_e;

  localparam gray_mode_e GRAY_RESET = GRAY_MAX;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    COMMIT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - active-low button synchronizer and debouncer with a one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic stable_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;

  // The counter only runs while the synced level disagrees with the accepted one,
  // so any bounce back to the stable level restarts the qualification window.
  always_comb begin
    sync_d   = {sync_q[0], btn_n};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign stable_n = stable_q;
  assign press    = press_q;

endmodule

// File: rtl/frame_mode_sched.sv
// rtl/frame_mode_sched.sv - frame-synchronous gray-mode commit, vsync timeout and per-frame brightness
// Define BRIGHT_IIR_EN to smooth brightness with a 1/2^IIR_SHIFT IIR; otherwise it is sampled per frame.
module frame_mode_sched
  import miniled_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 500000,
  parameter int VS_TIMEOUT     = 5000000,
  parameter int IIR_SHIFT      = 2,
  parameter int VS_ACTIVE_HIGH = 1
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_rms_n,
  input  logic       I_max_n,
  input  logic       I_ave_n,
  input  logic       I_cor_n,
  input  logic       I_vsync,
  input  logic [7:0] I_bright,
  output logic [1:0] O_gray_mode,
  output logic       O_mode_chg,
  output logic [7:0] O_bright,
  output logic       O_frame_tick,
  output logic       O_no_video
);

  localparam int TW = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(VS_TIMEOUT - 1);

  if (IIR_SHIFT < 1 || IIR_SHIFT > 4) begin : g_bad_shift
    $error("IIR_SHIFT must be in 1..4");
  end

  logic [3:0] btn_n, stable_n, press;
  assign btn_n = {I_cor_n, I_ave_n, I_max_n, I_rms_n};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk      (I_clk),
      .rst_n    (I_rst_n),
      .btn_n    (btn_n[i]),
      .stable_n (stable_n[i]),
      .press    (press[i])
    );
  end

  logic [2:0]    vs_q, vs_d;
  logic          tick_q, tick_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          no_video_q, no_video_d;
  logic          pseudo_tick, upd_tick;

  always_comb begin
    vs_d       = {vs_q[1:0], I_vsync};
    tick_d     = (VS_ACTIVE_HIGH != 0) ? (vs_q[1] & ~vs_q[2]) : (~vs_q[1] & vs_q[2]);
    to_cnt_d   = to_cnt_q + 1'b1;
    no_video_d = no_video_q;
    pseudo_tick = 1'b0;
    if (tick_q) begin
      to_cnt_d   = '0;
      no_video_d = 1'b0;
    end else if (to_cnt_q == TO_MAX) begin
      to_cnt_d    = '0;
      no_video_d  = 1'b1;
      pseudo_tick = 1'b1;
    end
    upd_tick = tick_q | pseudo_tick;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_q       <= {3{(VS_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1}};
      tick_q     <= 1'b0;
      to_cnt_q   <= '0;
      no_video_q <= 1'b0;
    end else begin
      vs_q       <= vs_d;
      tick_q     <= tick_d;
      to_cnt_q   <= to_cnt_d;
      no_video_q <= no_video_d;
    end
  end

  gray_mode_e   req, pend_q, pend_d, mode_q, mode_d;
  sched_state_e state_q, state_d;
  logic         chg_q, chg_d;
  logic         press_any;

  always_comb begin
    press_any = |press;
    req = mode_q;
    if (!stable_n[0])      req = GRAY_RMS;
    else if (!stable_n[1]) req = GRAY_MAX;
    else if (!stable_n[2]) req = GRAY_AVE;
    else if (!stable_n[3]) req = GRAY_COR;

    state_d = state_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    chg_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_any && req != mode_q) begin
          state_d = PEND;
          pend_d  = req;
        end
      end
      PEND: begin
        // A press back to the live mode withdraws the request, even on a tick.
        if (press_any && req == mode_q) begin
          state_d = IDLE;
        end else begin
          if (press_any) pend_d = req;
          if (upd_tick || no_video_q) begin
            state_d = COMMIT;
            mode_d  = pend_d;
            chg_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
      pend_q  <= GRAY_RESET;
      mode_q  <= GRAY_RESET;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      chg_q   <= chg_d;
    end
  end

  logic [7:0] bright_q, bright_d;

`ifdef BRIGHT_IIR_EN
  localparam int AW = 8 + IIR_SHIFT;
  logic [AW-1:0] acc_q, acc_d;
  logic          seeded_q, seeded_d;

  // acc holds 2^IIR_SHIFT times the filtered value; its steady state is bounded below 2^AW.
  always_comb begin
    acc_d    = acc_q;
    seeded_d = seeded_q;
    if (upd_tick) begin
      seeded_d = 1'b1;
      if (!seeded_q) acc_d = AW'(I_bright) << IIR_SHIFT;
      else           acc_d = acc_q - (acc_q >> IIR_SHIFT) + AW'(I_bright);
    end
    bright_d = acc_d[AW-1:IIR_SHIFT];
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      acc_q    <= '0;
      seeded_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      seeded_q <= seeded_d;
    end
  end
`else
  always_comb begin
    bright_d = upd_tick ? I_bright : bright_q;
  end
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) bright_q <= 8'd0;
    else          bright_q <= bright_d;
  end

  assign O_gray_mode  = mode_q;
  assign O_mode_chg   = chg_q;
  assign O_bright     = bright_q;
  assign O_frame_tick = tick_q;
  assign O_no_video   = no_video_q;

endmodule
